// File: rtl/axis_pkt_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : axis_pkt_fifo
//  Brief    : Synchronous AXI-Stream FIFO, first-word-fall-through, with an
//             optional store-and-forward packet mode keyed on tlast.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_pkt_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int PACKET_MODE = 1
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic [$clog2(DEPTH):0]  fill_count,
    output logic [$clog2(DEPTH):0]  pkt_count,
    output logic                    full,
    output logic                    empty
);

    localparam int              c_AW      = $clog2(DEPTH);
    localparam int              c_CW      = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH   = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

    // Each entry holds {tlast, tdata}
    logic [DATA_WIDTH:0] r_mem [DEPTH];
    logic [c_AW-1:0]     r_wr_ptr;
    logic [c_AW-1:0]     r_rd_ptr;
    logic [c_CW-1:0]     r_fill;
    logic [c_CW-1:0]     r_pkt;
    logic [DATA_WIDTH:0] w_head;
    logic                w_wr;
    logic                w_rd;
    logic                w_wr_last;
    logic                w_rd_last;

    assign full          = (r_fill == c_DEPTH);
    assign empty         = (r_fill == '0);
    assign fill_count    = r_fill;
    assign pkt_count     = r_pkt;
    assign s_axis_tready = !full && !areset;

    assign w_head    = r_mem[r_rd_ptr];
    assign w_wr      = s_axis_tvalid && s_axis_tready;
    assign w_rd      = m_axis_tvalid && m_axis_tready;
    assign w_wr_last = w_wr && s_axis_tlast;
    assign w_rd_last = w_rd && w_head[DATA_WIDTH];

    assign m_axis_tdata = m_axis_tvalid ? w_head[DATA_WIDTH-1:0] : '0;
    assign m_axis_tlast = m_axis_tvalid && w_head[DATA_WIDTH];

    always_ff @(posedge aclk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            r_pkt    <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_wr, w_rd})
                2'b10:   r_fill <= r_fill + c_CNT_ONE;
                2'b01:   r_fill <= r_fill - c_CNT_ONE;
                default: ;
            endcase
            case ({w_wr_last, w_rd_last})
                2'b10:   r_pkt <= r_pkt + c_CNT_ONE;
                2'b01:   r_pkt <= r_pkt - c_CNT_ONE;
                default: ;
            endcase
        end
    end

    generate
        if (PACKET_MODE != 0) begin : g_packet
            // A full FIFO with no complete packet would deadlock, so drain it
            // cut-through until the oversized packet's tlast leaves.
            logic r_flush;

            always_ff @(posedge aclk) begin
                if (areset) begin
                    r_flush <= 1'b0;
                end else if (w_rd_last) begin
                    r_flush <= 1'b0;
                end else if (full && (r_pkt == '0)) begin
                    r_flush <= 1'b1;
                end
            end

            assign m_axis_tvalid = !empty && ((r_pkt != '0) || r_flush);
        end else begin : g_cut_through
            assign m_axis_tvalid = !empty;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_pkt_fifo
//  Brief    : Self-checking bench for axis_pkt_fifo; cut-through (dut 0) and
//             packet-mode (dut 1) instances against a queue-style model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_pkt_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 5;
    localparam int MB    = 64;

    logic aclk   = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    logic [DW-1:0] s_data [2];
    logic          s_valid[2];
    logic          s_last [2];
    logic          s_ready[2];
    logic [DW-1:0] m_data [2];
    logic          m_valid[2];
    logic          m_last [2];
    logic          m_ready[2];
    logic [CW-1:0] fill   [2];
    logic [CW-1:0] pkt    [2];
    logic          full   [2];
    logic          empty  [2];

    axis_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PACKET_MODE(0)) dut_ct (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_data[0]), .s_axis_tvalid(s_valid[0]), .s_axis_tlast(s_last[0]),
        .s_axis_tready(s_ready[0]),
        .m_axis_tdata(m_data[0]), .m_axis_tvalid(m_valid[0]), .m_axis_tlast(m_last[0]),
        .m_axis_tready(m_ready[0]),
        .fill_count(fill[0]), .pkt_count(pkt[0]), .full(full[0]), .empty(empty[0])
    );

    axis_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PACKET_MODE(1)) dut_pk (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_data[1]), .s_axis_tvalid(s_valid[1]), .s_axis_tlast(s_last[1]),
        .s_axis_tready(s_ready[1]),
        .m_axis_tdata(m_data[1]), .m_axis_tvalid(m_valid[1]), .m_axis_tlast(m_last[1]),
        .m_axis_tready(m_ready[1]),
        .fill_count(fill[1]), .pkt_count(pkt[1]), .full(full[1]), .empty(empty[1])
    );

    int total = 0;
    int bad   = 0;

    // Reference model: a circular list of {tlast,data} beats per instance
    logic [DW:0] mbuf  [2][MB];
    int          mhead [2];
    int          mcnt  [2];
    bit          mflush[2];

    function automatic int m_pkt(int k);
        int n = 0;
        for (int i = 0; i < mcnt[k]; i++)
            if (mbuf[k][(mhead[k] + i) % MB][DW]) n++;
        return n;
    endfunction

    function automatic bit m_full(int k);
        return mcnt[k] == DEPTH;
    endfunction

    function automatic bit m_rdy(int k);
        return !m_full(k) && !areset;
    endfunction

    function automatic bit m_val(int k);
        return (mcnt[k] > 0) && (k == 0 || m_pkt(k) > 0 || mflush[k]);
    endfunction

    function automatic logic [DW:0] m_head(int k);
        return m_val(k) ? mbuf[k][mhead[k]] : '0;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h want %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic half_check();
        logic [DW:0] h;
        @(negedge aclk);
        for (int k = 0; k < 2; k++) begin
            h = m_head(k);
            chk("s_ready", k, 32'(s_ready[k]), 32'(m_rdy(k)));
            chk("m_valid", k, 32'(m_valid[k]), 32'(m_val(k)));
            chk("m_data",  k, 32'(m_data[k]),  32'(h[DW-1:0]));
            chk("m_last",  k, 32'(m_last[k]),  32'(h[DW]));
            chk("fill",    k, 32'(fill[k]),    32'(mcnt[k]));
            chk("pkt",     k, 32'(pkt[k]),     32'(m_pkt(k)));
            chk("full",    k, 32'(full[k]),    32'(m_full(k)));
            chk("empty",   k, 32'(empty[k]),   32'(mcnt[k] == 0));
        end
    endtask

    task automatic clk_edge();
        bit          wr, rd, setf;
        logic [DW:0] hd;
        @(posedge aclk);
        for (int k = 0; k < 2; k++) begin
            if (areset) begin
                mcnt[k] = 0; mhead[k] = 0; mflush[k] = 1'b0;
            end else begin
                wr   = s_valid[k] && m_rdy(k);
                rd   = m_val(k) && m_ready[k];
                hd   = mbuf[k][mhead[k]];
                setf = m_full(k) && (m_pkt(k) == 0);
                if (rd) begin
                    mhead[k] = (mhead[k] + 1) % MB;
                    mcnt[k]--;
                end
                if (wr) begin
                    mbuf[k][(mhead[k] + mcnt[k]) % MB] = {s_last[k], s_data[k]};
                    mcnt[k]++;
                end
                if (rd && hd[DW]) mflush[k] = 1'b0;
                else if (setf)    mflush[k] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic cycle();
        half_check();
        clk_edge();
    endtask

    task automatic drive(input int k, input bit v, input logic [DW-1:0] d, input bit l, input bit r);
        s_valid[k] = v; s_data[k] = d; s_last[k] = l; m_ready[k] = r;
    endtask

    task automatic idle();
        for (int k = 0; k < 2; k++) drive(k, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        areset = 1'b1;
        cycle();
        cycle();
        areset = 1'b0;
    endtask

    task automatic drain(input int n);
        idle();
        m_ready[0] = 1'b1;
        m_ready[1] = 1'b1;
        repeat (n) cycle();
        chk("drain_empty0", 0, 32'(empty[0]), 32'd1);
        chk("drain_empty1", 1, 32'(empty[1]), 32'd1);
    endtask

    task automatic rand_run(input int k, input int nbeats, input int last_pct);
        int          sent = 0, got = 0, cyc = 0;
        logic [DW:0] cur;
        bit          v, r, acc;
        cur = {1'b0, 8'($urandom)};
        while ((sent < nbeats || mcnt[k] > 0) && cyc < 2000) begin
            v = (sent < nbeats) && ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            if (sent == nbeats - 1) cur[DW] = (k == 1) ? 1'b1 : cur[DW];
            drive(k, v, cur[DW-1:0], cur[DW], r);
            half_check();
            acc = v && m_rdy(k);
            if (m_val(k) && r) got++;
            clk_edge();
            if (acc) begin
                sent++;
                cur = {($urandom_range(0, 99) < last_pct), 8'($urandom)};
            end
            cyc++;
        end
        chk("rand_got", k, 32'(got), 32'(nbeats));
        idle();
    endtask

    typedef struct {
        bit          v;  logic [DW-1:0] d;  bit l;  bit r;
        bit          ev; logic [DW-1:0] ed; bit el; int ef; bit erdy;
    } vec_t;

    vec_t tbl[9];

    initial begin
        bit          acc, saw_full;
        int          beat, outn, cyc;
        logic [DW:0] h;

        for (int k = 0; k < 2; k++) begin
            mhead[k] = 0; mcnt[k] = 0; mflush[k] = 1'b0;
        end
        idle();
        repeat (2) @(posedge aclk);
        #1;
        cycle();
        areset = 1'b0;

        // Cut-through directed vectors
        tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b1};
        tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1, 1'b1};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b1};
        tbl[3] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b1};
        tbl[4] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 2, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 2, 1'b1};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1, 1'b1};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b1};
        for (int i = 0; i < 9; i++) begin
            drive(0, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
            half_check();
            chk("tbl_valid", 0, 32'(m_valid[0]), 32'(tbl[i].ev));
            chk("tbl_data",  0, 32'(m_data[0]),  32'(tbl[i].ed));
            chk("tbl_last",  0, 32'(m_last[0]),  32'(tbl[i].el));
            chk("tbl_fill",  0, 32'(fill[0]),    32'(tbl[i].ef));
            chk("tbl_ready", 0, 32'(s_ready[0]), 32'(tbl[i].erdy));
            clk_edge();
        end
        idle();

        // Reset in the middle of a half-written packet
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
            cycle();
        end
        areset = 1'b1;
        cycle();
        cycle();
        areset = 1'b0;
        idle();
        half_check();
        chk("rst_fill",   1, 32'(fill[1]),    32'd0);
        chk("rst_pkt",    1, 32'(pkt[1]),     32'd0);
        chk("rst_empty",  1, 32'(empty[1]),   32'd1);
        chk("rst_valid",  1, 32'(m_valid[1]), 32'd0);
        chk("rst_sready", 1, 32'(s_ready[1]), 32'd1);
        clk_edge();

        // Packet mode, 8-beat packet
        for (int i = 1; i <= 8; i++) begin
            drive(1, 1'b1, 8'(i), (i == 8), 1'b1);
            half_check();
            chk("pk_hold", 1, 32'(m_valid[1]), 32'd0);
            clk_edge();
        end
        idle();
        m_ready[1] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            half_check();
            if (i == 1) chk("pk_count", 1, 32'(pkt[1]), 32'd1);
            chk("pk_valid", 1, 32'(m_valid[1]), 32'd1);
            chk("pk_data",  1, 32'(m_data[1]),  32'(i));
            chk("pk_last",  1, 32'(m_last[1]),  32'(i == 8));
            clk_edge();
        end
        drain(2);

        // Full / backpressure on the cut-through instance
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(0, 1'b1, 8'(i), 1'b0, 1'b0);
            cycle();
        end
        drive(0, 1'b1, 8'hFF, 1'b0, 1'b0);
        half_check();
        chk("bp_full",  0, 32'(full[0]),    32'd1);
        chk("bp_ready", 0, 32'(s_ready[0]), 32'd0);
        clk_edge();
        m_ready[0] = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            half_check();
            chk("bp_data", 0, 32'(m_data[0]), (i < 16) ? 32'(i) : 32'hFF);
            if (i == 0) chk("bp_no_wt", 0, 32'(s_ready[0]), 32'd0);
            if (i == 1) chk("bp_resume", 0, 32'(s_ready[0]), 32'd1);
            clk_edge();
            if (i == 1) s_valid[0] = 1'b0;
        end
        drain(2);

        // Simultaneous write and read at fill 5, tlast on both
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
            cycle();
        end
        drive(1, 1'b1, 8'h20, 1'b1, 1'b1);
        half_check();
        chk("sim_pre_fill", 1, 32'(fill[1]), 32'd5);
        clk_edge();
        idle();
        half_check();
        chk("sim_fill", 1, 32'(fill[1]), 32'd5);
        chk("sim_pkt",  1, 32'(pkt[1]),  32'd5);
        chk("sim_head", 1, 32'(m_data[1]), 32'h11);
        clk_edge();
        drain(8);

        // Randomised streams through both instances (wraps pointers)
        do_reset();
        rand_run(0, 40, 20);
        rand_run(1, 60, 20);
        drain(4);

        // Flush: 20-beat packet in packet mode
        do_reset();
        beat = 1; outn = 1; cyc = 0; saw_full = 1'b0;
        while ((beat <= 20 || mcnt[1] > 0) && cyc < 100) begin
            drive(1, (beat <= 20), 8'(beat), (beat == 20), 1'b1);
            half_check();
            if (full[1]) saw_full = 1'b1;
            acc = s_valid[1] && m_rdy(1);
            if (m_val(1)) begin
                h = m_head(1);
                chk("fl_order", 1, 32'(m_data[1]), 32'(outn));
                chk("fl_last",  1, 32'(m_last[1]), 32'(outn == 20));
                if (h[DW]) chk("fl_clear_pending", 1, 32'(mflush[1]), 32'd1);
                outn++;
            end
            clk_edge();
            if (acc) beat++;
            cyc++;
        end
        chk("fl_saw_full", 1, 32'(saw_full), 32'd1);
        chk("fl_count",    1, 32'(outn),     32'd21);
        chk("fl_cleared",  1, 32'(mflush[1]), 32'd0);
        idle();
        // Partial packet after flush clears must wait for its tlast
        drive(1, 1'b1, 8'h77, 1'b0, 1'b1);
        cycle();
        idle();
        m_ready[1] = 1'b1;
        half_check();
        chk("fl_post_hold", 1, 32'(m_valid[1]), 32'd0);
        clk_edge();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
